// File: rtl/range_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// range_pkg
// Shared definitions for the range scan controller: controller state encoding,
// default parameter values, bus widths and the wrapping index helper.
// No ports (package).
// -----------------------------------------------------------------------------
package range_pkg;

    // Default parameter values for range_scan_ctrl
    localparam int RAM_WORDS_DEF     = 256;
    localparam int RAM_ADDR_BITS_DEF = 8;
    localparam int RD_LAT_DEF        = 1;
    localparam int GUARD_DEF         = 2;

    // Fixed bus widths
    localparam int BASE_W  = 12;
    localparam int START_W = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        SCAN      = 3'd3,
        FINISH    = 3'd4
    } state_e;

    // Index of a scanned word: base plus address, wrapping modulo 2^BASE_W.
    function automatic logic [BASE_W-1:0] wrap_index(
        input logic [BASE_W-1:0] base_v,
        input logic [BASE_W-1:0] addr_v
    );
        return base_v + addr_v;
    endfunction

endpackage

// File: rtl/range_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// range_scan_ctrl_if
// Bundles the request, datapath handshake and result signals of the range scan
// controller.
//   master : requester / datapath side (drives run, abort, base, done, count)
//   slave  : controller side (drives go, start, busy, result_valid,
//            max_count, max_index)
// -----------------------------------------------------------------------------
interface range_scan_ctrl_if;
    import range_pkg::*;

    logic               run;
    logic               abort;
    logic [BASE_W-1:0]  base;
    logic               go;
    logic [START_W-1:0] start;
    logic               done;
    logic [COUNT_W-1:0] count;
    logic               busy;
    logic               result_valid;
    logic [COUNT_W-1:0] max_count;
    logic [BASE_W-1:0]  max_index;

    modport master (
        output run, abort, base, done, count,
        input  go, start, busy, result_valid, max_count, max_index
    );

    modport slave (
        input  run, abort, base, done, count,
        output go, start, busy, result_valid, max_count, max_index
    );
endinterface

// File: rtl/range_max_tracker.sv
// -----------------------------------------------------------------------------
// range_max_tracker
// Running maximum of a stream of (count, index) samples. The first valid sample
// after clear seeds the maximum; later samples replace it only when strictly
// greater, so ties keep the earliest (lowest-address) index.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   clear_i            : restart tracking (has priority over valid_i)
//   valid_i            : sample present this cycle
//   count_i, index_i   : sample value and its index
//   max_count_o        : largest count seen since clear
//   max_index_o        : index of that count
// -----------------------------------------------------------------------------
module range_max_tracker #(
    parameter int COUNT_W = 16,
    parameter int INDEX_W = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               valid_i,
    input  logic [COUNT_W-1:0] count_i,
    input  logic [INDEX_W-1:0] index_i,
    output logic [COUNT_W-1:0] max_count_o,
    output logic [INDEX_W-1:0] max_index_o
);

    logic               seen_q, seen_d;
    logic [COUNT_W-1:0] max_q,  max_d;
    logic [INDEX_W-1:0] idx_q,  idx_d;

    // Next running maximum: clear, seed/replace on strictly greater, or hold
    always_comb begin
        seen_d = seen_q;
        max_d  = max_q;
        idx_d  = idx_q;
        if (clear_i) begin
            seen_d = 1'b0;
            max_d  = '0;
            idx_d  = '0;
        end else if (valid_i && (!seen_q || (count_i > max_q))) begin
            seen_d = 1'b1;
            max_d  = count_i;
            idx_d  = index_i;
        end else begin
            seen_d = seen_q;
        end
    end

    // Running maximum registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q <= 1'b0;
            max_q  <= '0;
            idx_q  <= '0;
        end else begin
            seen_q <= seen_d;
            max_q  <= max_d;
            idx_q  <= idx_d;
        end
    end

    assign max_count_o = max_q;
    assign max_index_o = idx_q;

endmodule

// File: rtl/range_scan_ctrl.sv
// -----------------------------------------------------------------------------
// range_scan_ctrl
// Launches a range computation on an external datapath, waits for completion
// (ignoring done for GUARD cycles after the launch), reads back RAM_WORDS count
// words and publishes the largest count and its wrapped index.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : run/abort/base requests, go/start/done/count datapath
//                  handshake, busy/result_valid/max_count/max_index results
// All bus outputs are registered.
// -----------------------------------------------------------------------------
module range_scan_ctrl
    import range_pkg::*;
#(
    parameter int RAM_WORDS     = RAM_WORDS_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int RD_LAT        = RD_LAT_DEF,
    parameter int GUARD         = GUARD_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    range_scan_ctrl_if.slave  bus
);

    localparam int GUARD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam int CNT_W   = $clog2(RAM_WORDS + RD_LAT + 1);
    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [CNT_W-1:0]         SCAN_LAST = CNT_W'(RAM_WORDS + RD_LAT - 1);

    state_e                   state_q, state_d;
    logic [GUARD_W-1:0]       guard_q, guard_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]         scan_cnt_q, scan_cnt_d;
    logic [BASE_W-1:0]        base_q, base_d;
    logic                     rvalid_q, rvalid_d;
    logic [COUNT_W-1:0]       max_count_q, max_count_d;
    logic [BASE_W-1:0]        max_index_q, max_index_d;
    logic                     go_q, busy_q;
    logic [START_W-1:0]       start_q, start_d;

    logic                     abort_s;
    logic                     sample_valid_s;
    logic [RAM_ADDR_BITS-1:0] sample_addr_s;
    logic [BASE_W-1:0]        sample_index_s;
    logic [COUNT_W-1:0]       trk_count_s;
    logic [BASE_W-1:0]        trk_index_s;

    // Abort only matters once an operation is in progress
    assign abort_s = (state_q != IDLE) && bus.abort;

    // Scan cycle n carries the count for the address driven RD_LAT cycles earlier
    assign sample_valid_s = (state_q == SCAN) && (scan_cnt_q >= CNT_W'(RD_LAT));
    assign sample_addr_s  = RAM_ADDR_BITS'(scan_cnt_q - CNT_W'(RD_LAT));
    assign sample_index_s = wrap_index(base_q, BASE_W'(sample_addr_s));

    range_max_tracker #(
        .COUNT_W (COUNT_W),
        .INDEX_W (BASE_W)
    ) u_max_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (state_q == LAUNCH),
        .valid_i     (sample_valid_s),
        .count_i     (bus.count),
        .index_i     (sample_index_s),
        .max_count_o (trk_count_s),
        .max_index_o (trk_index_s)
    );

    // Next-state and next-output logic of the controller FSM
    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        addr_d      = addr_q;
        scan_cnt_d  = scan_cnt_q;
        base_d      = base_q;
        rvalid_d    = rvalid_q;
        max_count_d = max_count_q;
        max_index_d = max_index_q;
        if (abort_s) begin
            // Published results stay as they were; result_valid was already
            // cleared when this operation was accepted
            state_d  = IDLE;
            rvalid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.run) begin
                        state_d  = LAUNCH;
                        base_d   = bus.base;
                        rvalid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LAUNCH: begin
                    state_d = WAIT_DONE;
                    guard_d = '0;
                end
                WAIT_DONE: begin
                    // done may still be high from the previous range
                    if (guard_q < GUARD_W'(GUARD)) begin
                        guard_d = guard_q + GUARD_W'(1);
                    end else if (bus.done) begin
                        state_d    = SCAN;
                        addr_d     = '0;
                        scan_cnt_d = '0;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
                SCAN: begin
                    scan_cnt_d = scan_cnt_q + CNT_W'(1);
                    if (addr_q != LAST_ADDR) begin
                        addr_d = addr_q + RAM_ADDR_BITS'(1);
                    end else begin
                        addr_d = addr_q;
                    end
                    if (scan_cnt_q == SCAN_LAST) begin
                        state_d = FINISH;
                    end else begin
                        state_d = SCAN;
                    end
                end
                FINISH: begin
                    max_count_d = trk_count_s;
                    max_index_d = trk_index_s;
                    rvalid_d    = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == LAUNCH) begin
            start_d = START_W'(base_d);
        end else if (state_d == SCAN) begin
            start_d = START_W'(addr_d);
        end else begin
            start_d = '0;
        end
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            guard_q     <= '0;
            addr_q      <= '0;
            scan_cnt_q  <= '0;
            base_q      <= '0;
            rvalid_q    <= 1'b0;
            max_count_q <= '0;
            max_index_q <= '0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= '0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            addr_q      <= addr_d;
            scan_cnt_q  <= scan_cnt_d;
            base_q      <= base_d;
            rvalid_q    <= rvalid_d;
            max_count_q <= max_count_d;
            max_index_q <= max_index_d;
            go_q        <= (state_d == LAUNCH);
            busy_q      <= (state_d != IDLE);
            start_q     <= start_d;
        end
    end

    assign bus.go           = go_q;
    assign bus.busy         = busy_q;
    assign bus.start        = start_q;
    assign bus.result_valid = rvalid_q;
    assign bus.max_count    = max_count_q;
    assign bus.max_index    = max_index_q;

endmodule

// File: doc/range_scan_ctrl.md
RANGE_SCAN_CTRL -- requirements
Module: range_scan_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, number of count words held by the range datapath.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 8, read-address width (log2 RAM_WORDS).
REQ-003 SHALL have parameter RD_LAT, default 1, cycles from start (read address) to valid count.
REQ-004 SHALL have parameter GUARD, default 2, cycles after go during which done is ignored.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port run  input  1  one-cycle request to compute and scan a range.
REQ-008 SHALL have port abort  input  1  one-cycle request to cancel current operation.
REQ-009 SHALL have port base  input  12  first n of the range; sampled on accepted run.
REQ-010 SHALL have port go  output  1  one-cycle launch pulse to range datapath.
REQ-011 SHALL have port start  output  32  base value during launch, zero-extended read address during scan.
REQ-012 SHALL have port done  input  1  range datapath completion level.
REQ-013 SHALL have port count  input  16  iteration count read back from datapath.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port result_valid  output  1  high while max_count/max_index hold a completed scan.
REQ-016 SHALL have port max_count  output  16  largest count in last completed scan.
REQ-017 SHALL have port max_index  output  12  base + address of that largest count.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT_DONE, SCAN, FINISH.
REQ-019 IDLE: run accepted -> latch base, clear result_valid, go to LAUNCH; run while busy SHALL be ignored.
REQ-020 LAUNCH: one cycle; go=1, start={20'b0, base_latched}; next WAIT_DONE.
REQ-021 WAIT_DONE: done ignored for first GUARD cycles; afterwards done=1 -> SCAN with address 0.
REQ-022 SCAN: start={24'b0, addr} (zero-extended RAM_ADDR_BITS); addr increments 0..RAM_WORDS-1, then held; count for addr a sampled exactly RD_LAT cycles after a is driven.
REQ-023 SCAN SHALL last RAM_WORDS+RD_LAT cycles, then FINISH.
REQ-024 Compare: update max on strictly greater count; ties keep lowest address; running max initialised to address 0 sample.
REQ-025 max_index SHALL equal base_latched + addr, modulo 2^12 (wraps).
REQ-026 FINISH: one cycle; publish max_count/max_index, set result_valid=1; next IDLE.
REQ-027 max_count/max_index SHALL change only in FINISH or reset.
REQ-028 abort in any non-IDLE state -> IDLE next cycle, result_valid stays 0, go not reissued; abort in IDLE ignored.
REQ-029 run and abort same cycle in IDLE: run wins; in busy states: abort wins.
REQ-030 go SHALL never be high outside LAUNCH.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, go=0, busy=0, result_valid=0, max_count=0, max_index=0, start=0, addr=0.
REQ-032 Reset mid-scan SHALL discard partial results; first run after release SHALL behave as a fresh run.

Structure
REQ-033 State enum and default parameter constants SHALL live in shared package range_pkg.
REQ-034 Running-max compare/update SHALL be sub-module range_max_tracker (inputs valid, count, index; outputs max value/index, clear).

Verification
REQ-035 Bench model returns count[a]=a except count[37]=count[200]=16'h0200; run, base=12'h010 -> result_valid=1, max_count=16'h0200, max_index=12'h035.
REQ-036 run with base=12'hFF0, count[20]=max -> max_index=12'h004 (wrap).
REQ-037 done held high from previous run; go then done stays high -> no SCAN before GUARD expires; scan duration exactly 257 cycles (RAM_WORDS=256, RD_LAT=1).
REQ-038 abort asserted at addr 100 -> IDLE next cycle, result_valid=0, prior max_count unchanged; second run pulse during SCAN ignored.
REQ-039 reset_n pulsed low mid-WAIT_DONE -> all outputs 0 immediately; subsequent run completes with correct result.
REQ-040 All counts equal 16'h0007 -> max_count=16'h0007, max_index=base (lowest address).
